// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
// Segment patterns are 7 bits, ordered g..a.
package seven_seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam int NUM_DIGITS_DEF = 2;
  localparam int REFRESH_DIV_DEF = 100000;
  localparam int BLANK_CYCLES_DEF = 1000;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;
endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// valid/ready bundle that offers a new set of digit patterns.
// The pattern for digit d sits at seg_in[7d+6:7d].
interface seven_seg_scan_driver_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);
  logic [NUM_DIGITS*SEG_W-1:0] seg_in;
  logic seg_valid;
  logic seg_ready;

  modport master (
    output seg_in,
    output seg_valid,
    input  seg_ready
  );

  modport slave (
    input  seg_in,
    input  seg_valid,
    output seg_ready
  );
endinterface

// File: rtl/seven_seg_scan_driver_timer.sv
// Slot/digit counters for the scan: yields the current digit,
// the blank/drive phase and the frame-boundary strobe.
module seg_scan_timer
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  localparam int SW = $clog2(REFRESH_DIV),
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          enable,
  output logic [DW-1:0] digit_idx,
  output phase_t        phase,
  output logic          boundary
);
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_N = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

  logic [SW-1:0] slot_cnt;

  // Disabled means parked at slot 0 of digit 0, so re-enable
  // always opens with a frame boundary.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (!enable) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign phase = (slot_cnt < BLANK_N) ? PH_BLANK : PH_DRIVE;
  assign boundary = enable && (slot_cnt == '0) && (digit_idx == '0);
endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with a double-buffered
// pattern store that only swaps at frame boundaries.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    nRESET,
  input  logic                    enable,
  seven_seg_scan_driver_if.slave  bus,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        seg,
  output logic                    frame_start
);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = NUM_DIGITS * SEG_W;
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [DW-1:0]    digit_idx;
  phase_t           phase;
  logic             boundary;
  logic [PW-1:0]    pending;
  logic [PW-1:0]    active;
  logic             pending_full;
  logic             transfer;
  logic [SEG_W-1:0] digit_seg;

  seg_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .nRESET    (nRESET),
    .enable    (enable),
    .digit_idx (digit_idx),
    .phase     (phase),
    .boundary  (boundary)
  );

  assign bus.seg_ready = ~pending_full;
  assign transfer = bus.seg_valid && !pending_full;
  assign digit_seg = active[digit_idx*SEG_W +: SEG_W];

  // Swap has priority; ready is low then, so no transfer collides.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      pending      <= '0;
      active       <= '0;
      pending_full <= 1'b0;
    end else if (boundary && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (transfer) begin
      pending      <= bus.seg_in;
      pending_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      an          <= '1;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      an          <= '1;
      seg         <= SEG_OFF;
      if (enable && phase == PH_DRIVE) begin
        an  <= ~(AN_ONE << digit_idx);
        seg <= ~digit_seg;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed scenarios plus random
// traffic, checked against a frame-arithmetic reference model.
module tb_seven_seg_scan_driver;
  localparam int N = 2;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = N * R;

  logic         clk = 1'b0;
  logic         nRESET;
  logic         enable;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         frame_start;
  int           checks = 0;
  int           fails = 0;

  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .nRESET      (nRESET),
    .enable      (enable),
    .bus         (bus),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference: t counts enabled cycles since the scan (re)started;
  // slot, digit and boundary follow from t by plain arithmetic.
  int           t;
  int           m_dig;
  bit           m_bnd;
  bit           m_full;
  logic [N*7-1:0] m_act;
  logic [N*7-1:0] m_pend;
  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_fs;

  always @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      t = 0; m_full = 0; m_act = '0; m_pend = '0;
      e_an = '1; e_seg = 7'h7F; e_fs = 0;
    end else begin
      m_bnd = enable && (t % F == 0);
      e_fs = m_bnd;
      e_an = '1;
      e_seg = 7'h7F;
      if (enable && (t % R) >= B) begin
        m_dig = (t / R) % N;
        e_an[m_dig] = 1'b0;
        e_seg = ~m_act[m_dig*7 +: 7];
      end
      if (m_bnd && m_full) begin
        m_act = m_pend;
        m_full = 0;
      end else if (bus.seg_valid && !m_full) begin
        m_pend = bus.seg_in;
        m_full = 1;
      end
      t = enable ? t + 1 : 0;
    end
  end

  task automatic test_reset;
    nRESET = 0; enable = 0;
    bus.seg_valid = 0; bus.seg_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, frame_start} !== {2'b11, 7'h7F, 1'b0}) begin
      fails++;
      $display("FAIL reset an=%b seg=%h fs=%b want 11 7f 0",
               an, seg, frame_start);
    end
    checks++;
    if (bus.seg_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", bus.seg_ready);
    end
    nRESET = 1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL disabled an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
    end
  endtask

  task automatic test_idle_scan;
    int nfs;
    bit lit;
    nfs = 0; lit = 0;
    enable = 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL scan an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
      if (frame_start) nfs++;
      if (seg !== 7'h7F) lit = 1;
    end
    checks++;
    if (nfs != 2) begin
      fails++;
      $display("FAIL frame_count got %0d want 2", nfs);
    end
    checks++;
    if (lit) begin
      fails++;
      $display("FAIL idle_seg got lit want 7f throughout");
    end
  endtask

  task automatic test_load;
    bit s79;
    bit s40;
    s79 = 0; s40 = 0;
    repeat (5) @(negedge clk);
    // digit1 shows "0", digit0 shows "1"
    bus.seg_in = {7'h3F, 7'h06};
    bus.seg_valid = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.seg_valid = 0;
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL load an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
      if (an == 2'b10 && seg == 7'h79) s79 = 1;
      if (an == 2'b01 && seg == 7'h40) s40 = 1;
    end
    checks++;
    if (!(s79 && s40)) begin
      fails++;
      $display("FAIL load_digits seen79=%b seen40=%b want 1 1", s79, s40);
    end
  endtask

  task automatic test_hold_valid(output logic [N*7-1:0] b_val);
    logic [N*7-1:0] a_val;
    logic [6:0] last_d0;
    a_val = 14'($urandom);
    b_val = 14'($urandom);
    last_d0 = 'x;
    bus.seg_in = a_val;
    bus.seg_valid = 1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL hold an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
      bus.seg_in = b_val;
      if (i == 40) bus.seg_valid = 0;
      if (an == 2'b10) last_d0 = seg;
    end
    checks++;
    if (last_d0 !== ~b_val[6:0]) begin
      fails++;
      $display("FAIL hold_final got %h want %h", last_d0, ~b_val[6:0]);
    end
  endtask

  task automatic test_boundary_transfer(input logic [N*7-1:0] prev);
    logic [N*7-1:0] c_val;
    bit found;
    int first;
    c_val = 14'($urandom);
    c_val[6:0] = prev[6:0] ^ 7'h55;
    found = 0;
    first = -1;
    for (int i = 0; i < 48 && !found; i++) begin
      @(negedge clk);
      if (t % F == 0 && !m_full && enable) found = 1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL bnd_find got none want boundary within 48 cycles");
    end
    bus.seg_in = c_val;
    bus.seg_valid = 1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus.seg_valid = 0;
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL bnd an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
      if (first < 0 && an == 2'b10 && seg == ~c_val[6:0]) first = k;
    end
    checks++;
    if (first != F + B + 1) begin
      fails++;
      $display("FAIL bnd_latency got %0d want %0d", first, F + B + 1);
    end
  endtask

  task automatic test_enable_drop;
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (enable && t % F == R + 4) found = 1;
    end
    checks++;
    if (!found || an !== 2'b01) begin
      fails++;
      $display("FAIL drop_pre an=%b found=%b want 01 1", an, found);
    end
    enable = 0;
    @(negedge clk);
    checks++;
    if ({an, seg, frame_start} !== {2'b11, 7'h7F, 1'b0}) begin
      fails++;
      $display("FAIL drop an=%b seg=%h fs=%b want 11 7f 0",
               an, seg, frame_start);
    end
    repeat (4) @(negedge clk);
    enable = 1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL reenable an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
      if (k == 1) begin
        checks++;
        if ({frame_start, an} !== {1'b1, 2'b11}) begin
          fails++;
          $display("FAIL reenable_fs fs=%b an=%b want 1 11", frame_start, an);
        end
      end
      if (k == B + 1) begin
        checks++;
        if (an !== 2'b10) begin
          fails++;
          $display("FAIL reenable_d0 an=%b want 10", an);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [N*7-1:0] d_val;
    bit lit;
    lit = 0;
    d_val = 14'($urandom) | 14'h0081;
    repeat (3) @(negedge clk);
    bus.seg_in = d_val;
    bus.seg_valid = 1;
    @(negedge clk);
    bus.seg_valid = 0;
    @(negedge clk);
    #2 nRESET = 0;
    #1;
    checks++;
    if ({an, seg, frame_start, bus.seg_ready} !==
        {2'b11, 7'h7F, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset an=%b seg=%h fs=%b rdy=%b want 11 7f 0 1",
               an, seg, frame_start, bus.seg_ready);
    end
    @(negedge clk);
    nRESET = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL post_reset an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
      if (seg !== 7'h7F) lit = 1;
    end
    checks++;
    if (lit) begin
      fails++;
      $display("FAIL post_reset_blank got lit want 7f throughout");
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_start, bus.seg_ready} !==
          {e_an, e_seg, e_fs, ~m_full}) begin
        fails++;
        $display("FAIL random an=%b seg=%h fs=%b rdy=%b want %b %h %b %b",
                 an, seg, frame_start, bus.seg_ready,
                 e_an, e_seg, e_fs, ~m_full);
      end
      checks++;
      if ($countones(~an) > 1) begin
        fails++;
        $display("FAIL one_anode an=%b want at most one low", an);
      end
      enable = ($urandom_range(0, 31) != 0);
      bus.seg_valid = ($urandom_range(0, 3) == 0);
      bus.seg_in = 14'($urandom);
    end
  endtask

  initial begin
    logic [N*7-1:0] b_last;
    test_reset();
    test_idle_scan();
    test_load();
    test_hold_valid(b_last);
    test_boundary_transfer(b_last);
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
